// File: rtl/fp_pipe_skid_stage.sv
// Elastic valid/ready stage for the FP datapath: main register plus one skid entry.
// in_ready is taken from the state register alone, so it has no combinational path from out_ready.
module fp_pipe_skid_stage #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 52,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [MAN_W-1:0] in_sum,
  input  logic [MAN_W-1:0] in_sum_pos,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EXP_W-1:0] out_exp,
  output logic [MAN_W-1:0] out_sum,
  output logic [MAN_W-1:0] out_sum_pos,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [EXP_W-1:0] main_exp_q, main_exp_d, skid_exp_q, skid_exp_d;
  logic [MAN_W-1:0] main_sum_q, main_sum_d, skid_sum_q, skid_sum_d;
  logic [MAN_W-1:0] main_pos_q, main_pos_d, skid_pos_q, skid_pos_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic accept;
  logic deliver;

  assign in_ready    = (state_q != ST_FULL);
  assign out_valid   = (state_q != ST_EMPTY);
  assign accept      = in_valid & in_ready;
  assign deliver     = out_valid & out_ready;
  assign occupancy   = state_q;
  assign out_exp     = main_exp_q;
  assign out_sum     = main_sum_q;
  assign out_sum_pos = main_pos_q;
  assign stall_cnt   = stall_cnt_q;

  always_comb begin
    state_d    = state_q;
    main_exp_d = main_exp_q;
    main_sum_d = main_sum_q;
    main_pos_d = main_pos_q;
    skid_exp_d = skid_exp_q;
    skid_sum_d = skid_sum_q;
    skid_pos_d = skid_pos_q;

    unique case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          main_exp_d = in_exp;
          main_sum_d = in_sum;
          main_pos_d = in_sum_pos;
          state_d    = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && deliver) begin
          main_exp_d = in_exp;
          main_sum_d = in_sum;
          main_pos_d = in_sum_pos;
        end else if (accept) begin
          skid_exp_d = in_exp;
          skid_sum_d = in_sum;
          skid_pos_d = in_sum_pos;
          state_d    = ST_FULL;
        end else if (deliver) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (deliver) begin
          main_exp_d = skid_exp_q;
          main_sum_d = skid_sum_q;
          main_pos_d = skid_pos_q;
          state_d    = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    // Flush overrides any transition, including an accept in the same cycle.
    if (flush) begin
      state_d    = ST_EMPTY;
      main_exp_d = '0;
      main_sum_d = '0;
      main_pos_d = '0;
      skid_exp_d = '0;
      skid_sum_d = '0;
      skid_pos_d = '0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_EMPTY;
      main_exp_q  <= '0;
      main_sum_q  <= '0;
      main_pos_q  <= '0;
      skid_exp_q  <= '0;
      skid_sum_q  <= '0;
      skid_pos_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_exp_q  <= main_exp_d;
      main_sum_q  <= main_sum_d;
      main_pos_q  <= main_pos_d;
      skid_exp_q  <= skid_exp_d;
      skid_sum_q  <= skid_sum_d;
      skid_pos_q  <= skid_pos_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_fp_pipe_skid_stage.sv
// Directed bench for fp_pipe_skid_stage built with EXP_W=11, MAN_W=64, CNT_W=4 so that the
// width and stall-saturation cases share one instance.
module tb_fp_pipe_skid_stage;

  localparam int unsigned EXP_W = 11;
  localparam int unsigned MAN_W = 64;
  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [EXP_W-1:0] in_exp;
  logic [MAN_W-1:0] in_sum;
  logic [MAN_W-1:0] in_sum_pos;
  logic             out_valid;
  logic             out_ready;
  logic [EXP_W-1:0] out_exp;
  logic [MAN_W-1:0] out_sum;
  logic [MAN_W-1:0] out_sum_pos;
  logic [1:0]       occupancy;
  logic [CNT_W-1:0] stall_cnt;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  fp_pipe_skid_stage #(
    .EXP_W(EXP_W),
    .MAN_W(MAN_W),
    .CNT_W(CNT_W)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_exp     (in_exp),
    .in_sum     (in_sum),
    .in_sum_pos (in_sum_pos),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_exp    (out_exp),
    .out_sum    (out_sum),
    .out_sum_pos(out_sum_pos),
    .occupancy  (occupancy),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [EXP_W-1:0] e,
                       input logic [MAN_W-1:0] s, input logic [MAN_W-1:0] p);
    in_valid   = v;
    in_exp     = e;
    in_sum     = s;
    in_sum_pos = p;
  endtask

  task automatic check_head(input string tag, input logic [EXP_W-1:0] e,
                            input logic [MAN_W-1:0] s, input logic [MAN_W-1:0] p);
    check({tag, ".exp"}, 64'(out_exp), 64'(e));
    check({tag, ".sum"}, out_sum, s);
    check({tag, ".pos"}, out_sum_pos, p);
  endtask

  initial begin
    int unsigned exp_stall;
    rst       = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, '0, '0, '0);
    #12;
    check("rst.occ", 64'(occupancy), 64'd0);
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.in_ready", 64'(in_ready), 64'd1);
    check("rst.stall", 64'(stall_cnt), 64'd0);
    check_head("rst", '0, '0, '0);

    @(posedge clk); #1;
    rst = 1'b1;

    // Streaming: each entry appears right after its accepting edge.
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, EXP_W'(i), 64'h1000 + 64'(i), 64'(i));
      tick();
      check("stream.valid", 64'(out_valid), 64'd1);
      check("stream.occ", 64'(occupancy), 64'd1);
      check_head("stream", EXP_W'(i), 64'h1000 + 64'(i), 64'(i));
    end
    drive(1'b0, '0, '0, '0);
    tick();
    check("stream.drain_occ", 64'(occupancy), 64'd0);
    check("stream.stall", 64'(stall_cnt), 64'd0);

    // Back-pressure: A in main, B in skid, C held upstream.
    out_ready = 1'b0;
    drive(1'b1, 11'h00A, 64'hAAAA, 64'hA);
    tick();
    check("bp.occA", 64'(occupancy), 64'd1);
    drive(1'b1, 11'h00B, 64'hBBBB, 64'hB);
    tick();
    check("bp.occB", 64'(occupancy), 64'd2);
    check("bp.in_ready", 64'(in_ready), 64'd0);
    drive(1'b1, 11'h00C, 64'hCCCC, 64'hC);
    tick();
    check("bp.occC", 64'(occupancy), 64'd2);
    check_head("bp.holdA", 11'h00A, 64'hAAAA, 64'hA);
    out_ready = 1'b1;
    tick();
    check_head("bp.B", 11'h00B, 64'hBBBB, 64'hB);
    check("bp.in_ready_back", 64'(in_ready), 64'd1);
    tick();
    check_head("bp.C", 11'h00C, 64'hCCCC, 64'hC);
    check("bp.occ_after_C", 64'(occupancy), 64'd1);
    drive(1'b0, '0, '0, '0);
    tick();
    check("bp.drained", 64'(occupancy), 64'd0);
    check("bp.stall", 64'(stall_cnt), 64'd2);

    // Flush while FULL; out_ready high in the flush cycle so the stall count must not move.
    out_ready = 1'b0;
    drive(1'b1, 11'h00E, 64'hEEEE, 64'hE);
    tick();
    drive(1'b1, 11'h00F, 64'hFFFF, 64'hF);
    tick();
    check("fl.full", 64'(occupancy), 64'd2);
    check("fl.stall_pre", 64'(stall_cnt), 64'd3);
    flush = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 11'h00D, 64'hDDDD, 64'hD);
    tick();
    check("fl.occ", 64'(occupancy), 64'd0);
    check("fl.out_valid", 64'(out_valid), 64'd0);
    check_head("fl", '0, '0, '0);
    check("fl.stall", 64'(stall_cnt), 64'd3);

    // Flush in ONE with an accepted entry: the entry is discarded.
    flush = 1'b0;
    out_ready = 1'b0;
    drive(1'b1, 11'h011, 64'h1111, 64'h11);
    tick();
    flush = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 11'h0DD, 64'hD2D2, 64'hD2);
    check("fl1.in_ready", 64'(in_ready), 64'd1);
    tick();
    flush = 1'b0;
    drive(1'b0, '0, '0, '0);
    check("fl1.occ", 64'(occupancy), 64'd0);
    tick();
    check("fl1.no_D", 64'(out_valid), 64'd0);
    check("fl1.stall", 64'(stall_cnt), 64'd3);

    // Width and stall saturation: wide entry held for 20 stalled cycles.
    out_ready = 1'b0;
    drive(1'b1, 11'h7FF, 64'h8000_0000_0000_0001, '1);
    tick();
    drive(1'b0, '0, '0, '0);
    exp_stall = 3;
    for (int k = 1; k <= 20; k++) begin
      tick();
      exp_stall = (exp_stall == 15) ? 15 : exp_stall + 1;
      check("sat.stall", 64'(stall_cnt), 64'(exp_stall));
    end
    check_head("wide", 11'h7FF, 64'h8000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF);

    // Fill to FULL, then assert reset asynchronously mid-cycle.
    drive(1'b1, 11'h123, 64'h5555, 64'h55);
    tick();
    drive(1'b0, '0, '0, '0);
    check("rst2.full", 64'(occupancy), 64'd2);
    #2;
    rst = 1'b0;
    #1;
    check("rst2.occ", 64'(occupancy), 64'd0);
    check("rst2.out_valid", 64'(out_valid), 64'd0);
    check("rst2.in_ready", 64'(in_ready), 64'd1);
    check("rst2.stall", 64'(stall_cnt), 64'd0);
    check_head("rst2", '0, '0, '0);
    tick();
    rst = 1'b1;
    out_ready = 1'b1;
    tick();
    check("rst2.after_occ", 64'(occupancy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
